fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with bounded in-flight requests, redirect flush and response discard
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            reset_i,
   output logic            mem_rd_req_o,
   output logic [XLEN-1:0] mem_rd_addr_o,
   input  logic            mem_rd_gnt_i,
   input  logic            mem_rd_rvalid_i,
   input  logic [XLEN-1:0] mem_rd_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i
);
   localparam int              AW    = $clog2(DEPTH);
   localparam int              CW    = AW + 1;
   localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [CW:0]     LIM   = (CW+1)'(DEPTH);
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d, disc_q, disc_d, f_cnt_q, f_cnt_d;
   logic [AW-1:0]   f_wr_q, f_wr_d, f_rd_q, f_rd_d, iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] fifo_pc_q  [DEPTH];
   logic [XLEN-1:0] fifo_ins_q [DEPTH];
   logic [XLEN-1:0] iq_q       [DEPTH];
   logic            fire, rv, keep, pop;
   logic [CW:0]     occ;
   // next-state: grants advance pc, kept responses fill the buffer, redirect flushes and marks in-flight for discard
   always_comb begin
      fire    = req_q & mem_rd_gnt_i;
      rv      = mem_rd_rvalid_i & (out_q != '0);
      keep    = rv & (disc_q == '0) & ~redirect_i;
      pop     = (f_cnt_q != '0) & instr_ready_i & ~redirect_i;
      out_d   = out_q + CW'(fire) - CW'(rv);
      pc_d    = redirect_i ? (redirect_pc_i & ALIGN) : fire ? pc_q + XLEN'(4) : pc_q;
      disc_d  = redirect_i ? out_d : disc_q - CW'(rv & (disc_q != '0));
      f_wr_d  = redirect_i ? '0 : f_wr_q + AW'(keep);
      f_rd_d  = redirect_i ? '0 : f_rd_q + AW'(pop);
      f_cnt_d = redirect_i ? '0 : f_cnt_q + CW'(keep) - CW'(pop);
      iq_wr_d = redirect_i ? '0 : iq_wr_q + AW'(fire);
      iq_rd_d = redirect_i ? '0 : iq_rd_q + AW'(keep);
      occ     = {1'b0, f_cnt_d} + {1'b0, out_d};
      req_d   = occ < LIM;
   end
   // control state; request is registered so it never depends on inputs of the current cycle
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         pc_q    <= RESET_PC & ALIGN;
         out_q   <= '0;
         disc_q  <= '0;
         f_cnt_q <= '0;
         f_wr_q  <= '0;
         f_rd_q  <= '0;
         iq_wr_q <= '0;
         iq_rd_q <= '0;
         req_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         f_cnt_q <= f_cnt_d;
         f_wr_q  <= f_wr_d;
         f_rd_q  <= f_rd_d;
         iq_wr_q <= iq_wr_d;
         iq_rd_q <= iq_rd_d;
         req_q   <= req_d;
      end
   end
   // storage: issued-PC queue tags each kept response with its fetch address
   always_ff @(posedge clk_i) begin
      if (fire & ~redirect_i) iq_q[iq_wr_q] <= pc_q;
      if (keep) begin
         fifo_pc_q[f_wr_q]  <= iq_q[iq_rd_q];
         fifo_ins_q[f_wr_q] <= mem_rd_data_i;
      end
   end
   assign mem_rd_req_o  = req_q;
   assign mem_rd_addr_o = pc_q;
   assign instr_valid_o = f_cnt_q != '0;
   assign instr_o       = instr_valid_o ? fifo_ins_q[f_rd_q] : '0;
   assign instr_pc_o    = instr_valid_o ? fifo_pc_q[f_rd_q] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch stimulus with a queue-based memory/delivery scoreboard
module tb_fetch_unit;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_i = 1'b0, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, ready = 1'b0;
   logic [31:0] rdata = '0, rpc = '0;
   logic req, iv, w_req, w_iv;
   logic [31:0] addr, instr, ipc, w_addr, w_instr, w_ipc;
   fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_i(clk), .reset_i(reset_i), .mem_rd_req_o(req), .mem_rd_addr_o(addr),
      .mem_rd_gnt_i(gnt), .mem_rd_rvalid_i(rvalid), .mem_rd_data_i(rdata),
      .redirect_i(redirect), .redirect_pc_i(rpc), .instr_valid_o(iv),
      .instr_o(instr), .instr_pc_o(ipc), .instr_ready_i(ready));
   fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk_i(clk), .reset_i(reset_i), .mem_rd_req_o(w_req), .mem_rd_addr_o(w_addr),
      .mem_rd_gnt_i(1'b1), .mem_rd_rvalid_i(1'b0), .mem_rd_data_i(32'h0),
      .redirect_i(1'b0), .redirect_pc_i(32'h0), .instr_valid_o(w_iv),
      .instr_o(w_instr), .instr_pc_o(w_ipc), .instr_ready_i(1'b1));
   typedef struct {logic [31:0] a; int ep;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
   req_t pend[$];
   ent_t sb[$];
   req_t r;
   logic exp_req;
   logic [31:0] nf = '0;
   int total = 0, bad = 0, epoch = 0, rcnt = 0, ngrant = 0, ndeliv = 0;
   int p_gnt = 100, p_rv = 100, p_rdy = 100, p_rd = 0, p_sp = 0;
   int d0, g0;
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h13;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
      gnt      = $urandom_range(99) < p_gnt;
      rvalid   = !reset_i ? 1'b0 : pend.size() != 0 ? $urandom_range(99) < p_rv : $urandom_range(99) < p_sp;
      rdata    = (rvalid && pend.size() != 0) ? memf(pend[0].a) : $urandom;
      ready    = $urandom_range(99) < p_rdy;
      redirect = $urandom_range(99) < p_rd;
      rpc      = $urandom;
   endtask
   task automatic do_reset();
      step();
      reset_i = 1'b0;
      step();
      step();
      reset_i = 1'b1;
   endtask
   // monitor: memory model, delivery scoreboard and per-cycle output checks
   always begin
      @(negedge clk);
      #2;
      if (!reset_i) begin
         chk("rst_ctl", 32'({req, iv}), 32'h0);
         chk("rst_data", instr | ipc, 32'h0);
         pend.delete();
         sb.delete();
         epoch++;
         nf = 32'h0;
         rcnt = 0;
      end else begin
         exp_req = rcnt > 0 && (pend.size() + sb.size() < DEPTH);
         chk("req", 32'(req), 32'(exp_req));
         if (req) chk("addr", addr, nf);
         chk("valid", 32'(iv), 32'(sb.size() != 0));
         if (iv && sb.size() != 0) begin
            chk("head_pc", ipc, sb[0].pc);
            chk("head_ins", instr, sb[0].ins);
         end
         if (iv && ready && !redirect) begin
            if (sb.size() != 0) void'(sb.pop_front());
            ndeliv++;
         end
         if (rvalid && pend.size() != 0) begin
            r = pend.pop_front();
            if (r.ep == epoch && !redirect) sb.push_back('{r.a, memf(r.a)});
         end
         if (req && gnt) begin
            pend.push_back('{nf, epoch});
            ngrant++;
            if (!redirect) nf += 32'd4;
         end
         if (redirect) begin
            epoch++;
            sb.delete();
            nf = rpc & ~32'h3;
         end
         chk("bound", 32'(pend.size() + sb.size() <= DEPTH), 32'h1);
         rcnt++;
      end
   end
   initial begin
      repeat (3) step();
      step();
      reset_i = 1'b1;
      step(); #3;
      chk("wrap_a0", w_addr, 32'hFFFF_FFFC);
      chk("wrap_req", 32'(w_req), 32'h1);
      step(); #3;
      chk("wrap_a1", w_addr, 32'h0);
      chk("wrap_out", 32'(w_iv) | w_instr | w_ipc, 32'h0);
      repeat (20) step();
      d0 = ndeliv;
      repeat (10) step();
      chk("throughput", 32'(ndeliv - d0), 32'd10);
      p_rdy = 0;
      do_reset();
      g0 = ngrant;
      repeat (12) step();
      chk("fill_grants", 32'(ngrant - g0), 32'(DEPTH));
      #3 chk("fill_head", ipc, 32'h0);
      p_gnt = 0;
      p_rdy = 100;
      d0 = ndeliv;
      repeat (8) step();
      chk("drain", 32'(ndeliv - d0), 32'(DEPTH));
      p_gnt = 100;
      p_rv = 0;
      do_reset();
      step();
      step();
      step();
      gnt = 1'b0;
      redirect = 1'b1;
      rpc = 32'h103;
      step(); #3;
      chk("redir_addr", addr, 32'h100);
      p_rv = 100;
      repeat (10) step();
      p_rdy = 0;
      do_reset();
      step();
      step();
      step();
      gnt = 1'b1;
      ready = 1'b1;
      rvalid = 1'b0;
      redirect = 1'b1;
      rpc = 32'h200;
      step(); #3;
      chk("redir_nv", 32'(iv), 32'h0);
      p_gnt = 70; p_rv = 60; p_rdy = 60; p_rd = 5; p_sp = 20;
      for (int k = 0; k < 4; k++) begin
         repeat (400) step();
         #1 reset_i = 1'b0;
         #1 chk("async_rst", 32'({req, iv}) | instr | ipc, 32'h0);
         step();
         step();
         reset_i = 1'b1;
      end
      repeat (200) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
